// File: rtl/spmm_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spmm_sched_pkg
//  Brief    : Shared types for the SpMM tile scheduler (FSM states, command).
//  Revision : 1.0  initial release
// ============================================================================
package spmm_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RHS   = 2'd1,
        LHS   = 2'd2,
        DRAIN = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic new_rhs;
        logic ws;
        logic os;
        logic drain;
    } sched_cmd_t;

endpackage
`default_nettype wire

// File: rtl/spmm_sat_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : spmm_sat_cnt
//  Brief    : Up-counter that holds at all-ones instead of wrapping.
//  Revision : 1.0  initial release
// ============================================================================
module spmm_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/spmm_tile_sched.sv
`default_nettype none
// ============================================================================
//  Module   : spmm_tile_sched
//  Brief    : Sequences rhs load, lhs issue and output drain for SpMM tiles.
//             Define SPMM_SCHED_PERF_EN to build the saturating stall counter.
//  Revision : 1.0  initial release
// ============================================================================
module spmm_tile_sched
    import spmm_sched_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_new_rhs,
    input  logic             cmd_ws,
    input  logic             cmd_os,
    input  logic             cmd_drain,
    input  logic             lhs_ready_ns,
    input  logic             lhs_ready_ws,
    input  logic             lhs_ready_os,
    input  logic             lhs_ready_wos,
    output logic             lhs_start,
    output logic             lhs_ws,
    output logic             lhs_os,
    input  logic             rhs_ready,
    output logic             rhs_start,
    input  logic             out_ready,
    output logic             out_start,
    output logic             done,
    output logic [CNT_W-1:0] tile_cnt,
    output logic             err,
    output logic [31:0]      stall_cnt
);

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    sched_cmd_t       r_cmd;
    logic             r_rhs_valid;
    logic             r_out_pending;
    logic             r_err;
    logic             r_done;
    logic [CNT_W-1:0] r_tile_cnt;

    logic w_accept;
    logic w_legal;
    logic w_lhs_sel;
    logic w_rhs_fire;
    logic w_lhs_fire;
    logic w_out_fire;

    assign w_accept = cmd_valid && cmd_ready;
    assign w_legal  = (cmd_new_rhs || r_rhs_valid) && (!cmd_os || r_out_pending);

    always_comb begin
        w_lhs_sel   = 1'b0;
        w_rhs_fire  = 1'b0;
        w_lhs_fire  = 1'b0;
        w_out_fire  = 1'b0;
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        lhs_ws      = 1'b0;
        lhs_os      = 1'b0;

        unique case ({r_cmd.ws, r_cmd.os})
            2'b00:   w_lhs_sel = lhs_ready_ns;
            2'b10:   w_lhs_sel = lhs_ready_ws;
            2'b01:   w_lhs_sel = lhs_ready_os;
            default: w_lhs_sel = lhs_ready_wos;
        endcase

        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && w_legal) begin
                    w_state_nxt = cmd_new_rhs ? RHS : LHS;
                end
            end
            RHS: begin
                w_rhs_fire = rhs_ready && r_cmd.new_rhs;
                if (w_rhs_fire) w_state_nxt = LHS;
            end
            LHS: begin
                lhs_ws     = r_cmd.ws;
                lhs_os     = r_cmd.os;
                w_lhs_fire = w_lhs_sel;
                if (w_lhs_fire) w_state_nxt = r_cmd.drain ? DRAIN : IDLE;
            end
            DRAIN: begin
                w_out_fire = out_ready;
                if (w_out_fire) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Strobes are gated by reset so an in-flight handshake never completes
    // on the cycle the synchronous reset is applied.
    assign rhs_start = w_rhs_fire && !reset;
    assign lhs_start = w_lhs_fire && !reset;
    assign out_start = w_out_fire && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cmd         <= '0;
            r_rhs_valid   <= 1'b0;
            r_out_pending <= 1'b0;
            r_err         <= 1'b0;
            r_done        <= 1'b0;
            r_tile_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            if (w_accept) begin
                if (w_legal) begin
                    r_cmd <= '{new_rhs: cmd_new_rhs, ws: cmd_ws, os: cmd_os, drain: cmd_drain};
                end else begin
                    r_err <= 1'b1;
                end
            end
            if (w_rhs_fire) r_rhs_valid <= 1'b1;
            if (w_lhs_fire) begin
                r_out_pending <= 1'b1;
                r_tile_cnt    <= r_tile_cnt + CNT_W'(1);
                if (!r_cmd.ws)    r_rhs_valid <= 1'b0;
                if (!r_cmd.drain) r_done      <= 1'b1;
            end
            if (w_out_fire) begin
                r_out_pending <= 1'b0;
                r_done        <= 1'b1;
            end
        end
    end

    assign done     = r_done;
    assign tile_cnt = r_tile_cnt;
    assign err      = r_err;

`ifdef SPMM_SCHED_PERF_EN
    logic w_stall;

    assign w_stall = ((r_state == RHS)   && !rhs_ready) ||
                     ((r_state == LHS)   && !w_lhs_sel) ||
                     ((r_state == DRAIN) && !out_ready);

    spmm_sat_cnt #(
        .W (32)
    ) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (w_stall),
        .count (stall_cnt)
    );
`else
    assign stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spmm_tile_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spmm_tile_sched
//  Brief    : Scoreboard bench for spmm_tile_sched (expected strobes queued at
//             command acceptance, popped by an independent monitor).
//  Revision : 1.0  initial release
// ============================================================================
module tb_spmm_tile_sched;

    localparam int CNT_W = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_new_rhs = 1'b0, cmd_ws = 1'b0, cmd_os = 1'b0, cmd_drain = 1'b0;
    logic             lhs_ready_ns = 1'b1, lhs_ready_ws = 1'b1, lhs_ready_os = 1'b1, lhs_ready_wos = 1'b1;
    logic             lhs_start, lhs_ws, lhs_os;
    logic             rhs_ready = 1'b1, rhs_start;
    logic             out_ready = 1'b1, out_start;
    logic             done;
    logic [CNT_W-1:0] tile_cnt;
    logic             err;
    logic [31:0]      stall_cnt;

    spmm_tile_sched #(.CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_new_rhs(cmd_new_rhs), .cmd_ws(cmd_ws), .cmd_os(cmd_os), .cmd_drain(cmd_drain),
        .lhs_ready_ns(lhs_ready_ns), .lhs_ready_ws(lhs_ready_ws),
        .lhs_ready_os(lhs_ready_os), .lhs_ready_wos(lhs_ready_wos),
        .lhs_start(lhs_start), .lhs_ws(lhs_ws), .lhs_os(lhs_os),
        .rhs_ready(rhs_ready), .rhs_start(rhs_start),
        .out_ready(out_ready), .out_start(out_start),
        .done(done), .tile_cnt(tile_cnt), .err(err), .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    // kind: 0 rhs_start, 1 lhs_start (field = {ws,os}), 2 out_start, 3 done (field = tile_cnt)
    typedef struct {
        int kind;
        int field;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    bit  m_rhs = 0, m_outp = 0;
    int  m_tile = 0;

`ifdef SPMM_SCHED_PERF_EN
    localparam int STALL_EXP = 5;
`else
    localparam int STALL_EXP = 0;
`endif

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push(input int kind, input int field, input int at);
        ev_t e;
        e.kind = kind; e.field = field; e.cyc = at;
        exp_q.push_back(e);
    endtask

    // Monitor: one strobe/done event per cycle at most, compared in order.
    always @(negedge clock) begin
        int   n;
        ev_t  o;
        ev_t  e;
        n = int'(rhs_start) + int'(lhs_start) + int'(out_start);
        if (n > 1) check("one_start", n, 1);
        if (n > 0 || done) begin
            o.kind  = rhs_start ? 0 : lhs_start ? 1 : out_start ? 2 : 3;
            o.field = lhs_start ? int'({lhs_ws, lhs_os}) : (n == 0) ? int'(tile_cnt) : 0;
            o.cyc   = cyc;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", o.kind, o.cyc);
            end else begin
                e = exp_q.pop_front();
                check("ev_kind", o.kind, e.kind);
                check("ev_field", o.field, e.field);
                if (e.cyc >= 0) check("ev_cycle", o.cyc, e.cyc);
            end
        end
    end

    task automatic wait_empty();
        int t = 0;
        while (exp_q.size() > 0 && t < 300) begin
            @(posedge clock); #1; t++;
        end
        if (exp_q.size() > 0) begin
            checks++; errors++;
            $display("FAIL wait_events: got %0d pending events, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        m_rhs = 0; m_outp = 0; m_tile = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic send_cmd(input bit nr, input bit ws, input bit os, input bit dr,
                            input bit timed, input bit wait_end);
        int a, o, t;
        t = 0;
        while (!cmd_ready && t < 300) begin
            @(posedge clock); #1; t++;
        end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL cmd_ready_wait: got 0 expected 1");
        end
        {cmd_new_rhs, cmd_ws, cmd_os, cmd_drain} = {nr, ws, os, dr};
        cmd_valid = 1'b1;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        a = cyc;
        if ((nr || m_rhs) && (!os || m_outp)) begin
            o = nr ? 1 : 0;
            if (nr) push(0, 0, timed ? a : -1);
            push(1, int'({ws, os}), timed ? a + o : -1);
            m_tile = (m_tile + 1) % (1 << CNT_W);
            if (dr) push(2, 0, timed ? a + o + 1 : -1);
            push(3, m_tile, timed ? a + o + (dr ? 2 : 1) : -1);
            m_rhs  = ws;
            m_outp = !dr;
        end
        if (wait_end) wait_empty();
    endtask

    initial begin
        #1;
        do_reset();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_err", err, 0);
        check("rst_tile_cnt", tile_cnt, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_done", done, 0);

        // Reuse of rhs with nothing loaded is illegal
        send_cmd(0, 0, 0, 0, 1, 1);
        check("illegal_err", err, 1);
        check("illegal_idle", cmd_ready, 1);
        repeat (3) @(posedge clock);
        #1 check("err_sticky", err, 1);

        // Full path: rhs, lhs, drain with every ready high
        do_reset();
        send_cmd(1, 0, 0, 1, 1, 1);
        check("full_tile_cnt", tile_cnt, 1);
        check("full_err", err, 0);

        // Mode-specific ready selection: only the selected ready is high
        do_reset();
        {lhs_ready_ns, lhs_ready_ws, lhs_ready_os, lhs_ready_wos} = 4'b0100;
        send_cmd(1, 1, 0, 0, 1, 1);
        {lhs_ready_ns, lhs_ready_ws, lhs_ready_os, lhs_ready_wos} = 4'b0001;
        send_cmd(0, 1, 1, 0, 1, 1);
        {lhs_ready_ns, lhs_ready_ws, lhs_ready_os, lhs_ready_wos} = 4'b0010;
        send_cmd(0, 0, 1, 1, 1, 1);
        check("modes_tile_cnt", tile_cnt, 3);
        check("modes_err", err, 0);

        // Stall in LHS waiting for the ws ready
        do_reset();
        {lhs_ready_ns, lhs_ready_ws, lhs_ready_os, lhs_ready_wos} = 4'b1011;
        send_cmd(1, 1, 0, 0, 0, 0);
        @(posedge clock); #1;
        repeat (5) begin
            @(posedge clock); #1;
        end
        check("stall_no_lhs_start", lhs_start, 0);
        check("stall_cnt", stall_cnt, STALL_EXP);
        lhs_ready_ws = 1'b1;
        wait_empty();
        check("stall_cnt_hold", stall_cnt, STALL_EXP);

        // Reset while in DRAIN with out_ready high drops the handshake
        do_reset();
        out_ready = 1'b0;
        send_cmd(1, 0, 0, 1, 1, 0);
        repeat (2) begin
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        reset = 1'b1;
        exp_q.delete();
        m_rhs = 0; m_outp = 0; m_tile = 0;
        #3 check("rst_drain_out_start", out_start, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        check("rst_drain_idle", cmd_ready, 1);
        send_cmd(1, 0, 1, 0, 1, 1);
        check("rst_drain_os_err", err, 1);

        // Tile counter wrap
        do_reset();
        for (int i = 0; i < (1 << CNT_W) - 1; i++) send_cmd(1, 0, 0, 0, 1, 1);
        check("wrap_pre", tile_cnt, (1 << CNT_W) - 1);
        send_cmd(1, 0, 0, 0, 1, 1);
        check("wrap_post", tile_cnt, 0);

        repeat (2) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
